// File: rtl/pht_upd_sched.sv
// pht_upd_sched: buffers branch-resolution updates to the pattern history
// table and schedules them onto the PHT's single write port.
//
// Two update ports (upd0 older, upd1 younger) push {pc, taken} into a
// circular FIFO. A three-state scheduler drains the FIFO:
//   S_IDLE  - FIFO empty, no writes.
//   S_LAZY  - write only when the frontend is not using the PHT read port.
//   S_FORCE - stall the frontend and drain every cycle until empty.
// A head entry that waits STARVE_LIMIT lazy cycles forces a drain.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   upd0_*/upd1_*           update ports (valid/pc/taken in, ready out)
//   fe_rd_busy_i            frontend needs the PHT read port this cycle
//   fe_stall_o              frontend must not issue PHT lookups
//   pht_wr_req_o/_pc_o/_predictbit_o   PHT write port (FIFO head)
//   upd_cnt_o               FIFO occupancy
//   perf_force_cyc_o        saturating count of stall cycles
//                           (present only with PHT_UPD_PERF_EN defined)

`ifndef XLEN
`define XLEN 32
`endif

module pht_upd_sched #(
  parameter int UPD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              upd0_valid_i,
  input  logic [`XLEN-1:0]                  upd0_pc_i,
  input  logic                              upd0_taken_i,
  output logic                              upd0_ready_o,
  input  logic                              upd1_valid_i,
  input  logic [`XLEN-1:0]                  upd1_pc_i,
  input  logic                              upd1_taken_i,
  output logic                              upd1_ready_o,
  input  logic                              fe_rd_busy_i,
  output logic                              fe_stall_o,
  output logic                              pht_wr_req_o,
  output logic [`XLEN-1:0]                  pht_wr_pc_o,
  output logic                              pht_wr_predictbit_o,
`ifdef PHT_UPD_PERF_EN
  output logic [31:0]                       perf_force_cyc_o,
`endif
  output logic [$clog2(UPD_FIFO_DEPTH):0]   upd_cnt_o
);

  localparam int AW = $clog2(UPD_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] DEPTH     = CW'(UPD_FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_LM = SW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAZY, S_FORCE} state_t;

  state_t            state;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt, free, cnt_nxt;
  logic [SW-1:0]     starve;
  logic [`XLEN:0]    mem [UPD_FIFO_DEPTH];
  logic              push0, push1, pop;
  logic [AW-1:0]     wr_ptr1;

  always_comb begin
    free         = DEPTH - cnt;
    upd0_ready_o = (free >= CW'(1));
    upd1_ready_o = upd0_valid_i ? (free >= CW'(2)) : (free >= CW'(1));
    push0        = upd0_valid_i & upd0_ready_o;
    push1        = upd1_valid_i & upd1_ready_o;
    // upd1 lands behind upd0 when both push in the same cycle
    wr_ptr1      = push0 ? wr_ptr + AW'(1) : wr_ptr;

    pht_wr_req_o = 1'b0;
    case (state)
      S_LAZY:  pht_wr_req_o = ~fe_rd_busy_i;
      S_FORCE: pht_wr_req_o = (cnt != '0);
      default: pht_wr_req_o = 1'b0;
    endcase
    pop          = pht_wr_req_o;
    cnt_nxt      = cnt + CW'(push0) + CW'(push1) - CW'(pop);

    pht_wr_pc_o         = mem[rd_ptr][`XLEN:1];
    pht_wr_predictbit_o = mem[rd_ptr][0];
    fe_stall_o          = (state == S_FORCE);
    upd_cnt_o           = cnt;
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (push0) mem[wr_ptr]  <= {upd0_pc_i, upd0_taken_i};
    if (push1) mem[wr_ptr1] <= {upd1_pc_i, upd1_taken_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      starve <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt_nxt;
      starve <= '0;
      case (state)
        S_IDLE: begin
          if (push0 | push1) state <= S_LAZY;
        end
        S_LAZY: begin
          if (cnt_nxt == '0)
            state <= S_IDLE;
          else if (cnt_nxt == DEPTH || (!pop && starve == STARVE_LM))
            state <= S_FORCE;
          else if (!pop)
            starve <= starve + SW'(1);
        end
        S_FORCE: begin
          if (cnt_nxt == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PHT_UPD_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      perf_force_cyc_o <= '0;
    else if (fe_stall_o && perf_force_cyc_o != '1)
      perf_force_cyc_o <= perf_force_cyc_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pht_upd_sched.sv
// Directed bench for pht_upd_sched (UPD_FIFO_DEPTH=4, STARVE_LIMIT=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// one further time unit later, well away from the next edge.

`ifndef XLEN
`define XLEN 32
`endif

module tb_pht_upd_sched;
  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             upd0_valid_i, upd0_taken_i, upd0_ready_o;
  logic [`XLEN-1:0] upd0_pc_i;
  logic             upd1_valid_i, upd1_taken_i, upd1_ready_o;
  logic [`XLEN-1:0] upd1_pc_i;
  logic             fe_rd_busy_i, fe_stall_o;
  logic             pht_wr_req_o, pht_wr_predictbit_o;
  logic [`XLEN-1:0] pht_wr_pc_o;
  logic [2:0]       upd_cnt_o;
`ifdef PHT_UPD_PERF_EN
  logic [31:0]      perf_force_cyc_o;
`endif

  int total = 0;
  int bad   = 0;

  pht_upd_sched #(.UPD_FIFO_DEPTH(4), .STARVE_LIMIT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .upd0_valid_i(upd0_valid_i), .upd0_pc_i(upd0_pc_i),
    .upd0_taken_i(upd0_taken_i), .upd0_ready_o(upd0_ready_o),
    .upd1_valid_i(upd1_valid_i), .upd1_pc_i(upd1_pc_i),
    .upd1_taken_i(upd1_taken_i), .upd1_ready_o(upd1_ready_o),
    .fe_rd_busy_i(fe_rd_busy_i), .fe_stall_o(fe_stall_o),
    .pht_wr_req_o(pht_wr_req_o), .pht_wr_pc_o(pht_wr_pc_o),
    .pht_wr_predictbit_o(pht_wr_predictbit_o),
`ifdef PHT_UPD_PERF_EN
    .perf_force_cyc_o(perf_force_cyc_o),
`endif
    .upd_cnt_o(upd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Checks the write port presents the given head and is requesting.
  task automatic chk_wr(input string tag, input logic [31:0] pc, input logic pb, input logic [2:0] cnt);
    chk({tag, ".req"}, 64'(pht_wr_req_o), 64'd1);
    chk({tag, ".pc"},  64'(pht_wr_pc_o), 64'(pc));
    chk({tag, ".pb"},  64'(pht_wr_predictbit_o), 64'(pb));
    chk({tag, ".cnt"}, 64'(upd_cnt_o), 64'(cnt));
  endtask

  task automatic push(input logic v0, input logic [31:0] p0, input logic t0,
                      input logic v1, input logic [31:0] p1, input logic t1);
    upd0_valid_i = v0; upd0_pc_i = p0; upd0_taken_i = t0;
    upd1_valid_i = v1; upd1_pc_i = p1; upd1_taken_i = t1;
  endtask

  initial begin
    rst_i = 1'b1;
    fe_rd_busy_i = 1'b0;
    push(0, '0, 0, 0, '0, 0);
    #2;
    // reset state
    chk("rst.req",   64'(pht_wr_req_o), 64'd0);
    chk("rst.stall", 64'(fe_stall_o),   64'd0);
    chk("rst.cnt",   64'(upd_cnt_o),    64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    settle();
    chk("rel.rdy0", 64'(upd0_ready_o), 64'd1);
    chk("rel.rdy1", 64'(upd1_ready_o), 64'd1);

    // single push, drained the next cycle
    push(1, 32'h8000_0010, 1, 0, '0, 0);
    settle();
    chk("t1.rdy0", 64'(upd0_ready_o), 64'd1);
    tick();
    push(0, '0, 0, 0, '0, 0);
    settle();
    chk_wr("t1.w", 32'h8000_0010, 1'b1, 3'd1);
    tick(); settle();
    chk("t1.cnt", 64'(upd_cnt_o), 64'd0);
    chk("t1.req", 64'(pht_wr_req_o), 64'd0);
    chk("t1.stall", 64'(fe_stall_o), 64'd0);

    // dual push: A older than B
    push(1, 32'h0000_0100, 0, 1, 32'h0000_0204, 1);
    settle();
    chk("t2.rdy1", 64'(upd1_ready_o), 64'd1);
    tick();
    push(0, '0, 0, 0, '0, 0);
    settle();
    chk_wr("t2.wA", 32'h0000_0100, 1'b0, 3'd2);
    tick(); settle();
    chk_wr("t2.wB", 32'h0000_0204, 1'b1, 3'd1);
    tick(); settle();
    chk("t2.cnt", 64'(upd_cnt_o), 64'd0);
    chk("t2.req", 64'(pht_wr_req_o), 64'd0);

    // fill to depth while the read port is busy -> forced drain
    fe_rd_busy_i = 1'b1;
    push(1, 32'h0000_1000, 1, 1, 32'h0000_1004, 0);
    tick();
    push(1, 32'h0000_1008, 1, 1, 32'h0000_100c, 0);
    settle();
    chk("t3.lazyreq", 64'(pht_wr_req_o), 64'd0);
    chk("t3.lazycnt", 64'(upd_cnt_o), 64'd2);
    tick();
    push(0, '0, 0, 0, '0, 0);
    settle();
    chk("t3.rdy0", 64'(upd0_ready_o), 64'd0);
    chk("t3.rdy1", 64'(upd1_ready_o), 64'd0);
    chk("t3.stall", 64'(fe_stall_o), 64'd1);
    chk_wr("t3.w0", 32'h0000_1000, 1'b1, 3'd4);
    tick(); settle();
    chk_wr("t3.w1", 32'h0000_1004, 1'b0, 3'd3);
    chk("t3.stall1", 64'(fe_stall_o), 64'd1);
    tick(); settle();
    chk_wr("t3.w2", 32'h0000_1008, 1'b1, 3'd2);
    tick(); settle();
    chk_wr("t3.w3", 32'h0000_100c, 1'b0, 3'd1);
    tick(); settle();
    chk("t3.cnt", 64'(upd_cnt_o), 64'd0);
    chk("t3.stall_end", 64'(fe_stall_o), 64'd0);
    chk("t3.req_end", 64'(pht_wr_req_o), 64'd0);
`ifdef PHT_UPD_PERF_EN
    chk("t3.perf", 64'(perf_force_cyc_o), 64'd4);
`endif

    // starvation: one entry, read port busy for 16 lazy cycles
    push(1, 32'h0000_2000, 1, 0, '0, 0);
    tick();
    push(0, '0, 0, 0, '0, 0);
    settle();
    chk("t4.lazy1.req", 64'(pht_wr_req_o), 64'd0);
    for (int i = 0; i < 15; i++) tick();
    settle();
    chk("t4.lazy16.req", 64'(pht_wr_req_o), 64'd0);
    chk("t4.lazy16.stall", 64'(fe_stall_o), 64'd0);
    tick(); settle();
    chk("t4.force.stall", 64'(fe_stall_o), 64'd1);
    chk_wr("t4.w", 32'h0000_2000, 1'b1, 3'd1);
    tick(); settle();
    chk("t4.cnt", 64'(upd_cnt_o), 64'd0);
    chk("t4.stall_end", 64'(fe_stall_o), 64'd0);

    // count=3 with both ports valid: upd1 held until a pop frees a slot
    push(1, 32'h0000_3000, 0, 1, 32'h0000_3004, 1);
    tick();
    push(1, 32'h0000_3008, 0, 0, '0, 0);
    tick();
    push(1, 32'h0000_300c, 1, 1, 32'h0000_3010, 0);
    settle();
    chk("t5.cnt3", 64'(upd_cnt_o), 64'd3);
    chk("t5.rdy0", 64'(upd0_ready_o), 64'd1);
    chk("t5.rdy1", 64'(upd1_ready_o), 64'd0);
    tick();
    upd0_valid_i = 1'b0;
    settle();
    chk("t5.rdy1_full", 64'(upd1_ready_o), 64'd0);
    chk_wr("t5.w0", 32'h0000_3000, 1'b0, 3'd4);
    tick(); settle();
    chk("t5.rdy1_pop", 64'(upd1_ready_o), 64'd1);
    chk_wr("t5.w1", 32'h0000_3004, 1'b1, 3'd3);
    tick();
    upd1_valid_i = 1'b0;
    settle();
    chk_wr("t5.w2", 32'h0000_3008, 1'b0, 3'd3);
    tick(); settle();
    chk_wr("t5.w3", 32'h0000_300c, 1'b1, 3'd2);
    tick(); settle();
    chk_wr("t5.w4", 32'h0000_3010, 1'b0, 3'd1);
    tick(); settle();
    chk("t5.cnt", 64'(upd_cnt_o), 64'd0);

    // asynchronous reset mid-drain
    push(1, 32'h0000_4000, 1, 1, 32'h0000_4004, 1);
    tick();
    push(1, 32'h0000_4008, 1, 1, 32'h0000_400c, 1);
    tick();
    push(0, '0, 0, 0, '0, 0);
    tick(); tick(); settle();
    chk("t6.stall", 64'(fe_stall_o), 64'd1);
    chk_wr("t6.pre", 32'h0000_4008, 1'b1, 3'd2);
    rst_i = 1'b1;
    #1;
    chk("t6.req", 64'(pht_wr_req_o), 64'd0);
    chk("t6.cnt", 64'(upd_cnt_o), 64'd0);
    chk("t6.stall0", 64'(fe_stall_o), 64'd0);
`ifdef PHT_UPD_PERF_EN
    chk("t6.perf", 64'(perf_force_cyc_o), 64'd0);
`endif
    tick();
    rst_i = 1'b0;
    fe_rd_busy_i = 1'b0;
    tick(); settle();
    chk("t6.post.req", 64'(pht_wr_req_o), 64'd0);
    chk("t6.post.cnt", 64'(upd_cnt_o), 64'd0);
    tick(); settle();
    chk("t6.post2.req", 64'(pht_wr_req_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $fatal(1, "FAIL timeout observed=running expected=finished");
  end
endmodule
